// File: rtl/audio_if_pkg.sv
// Shared constants and width helpers for the TDM/I2S codec serial port.
// Default parameter values give the classic 2ch / 24-bit / 32-slot frame.
package audio_if_pkg;

    localparam logic MODE_LJ  = 1'b0;
    localparam logic MODE_I2S = 1'b1;

    localparam int DEF_DATA_W        = 24;
    localparam int DEF_SLOT_W        = 32;
    localparam int DEF_NUM_CH        = 2;
    localparam int DEF_BCLK_DIV_LOG2 = 2;

    // Index width for a field that counts 0..n-1; never zero so slices stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int frame_len(input int num_ch, input int slot_w, input int div_log2);
        return num_ch * slot_w * (1 << div_log2);
    endfunction

    localparam int DEF_FRAME_LEN = frame_len(DEF_NUM_CH, DEF_SLOT_W, DEF_BCLK_DIV_LOG2);

endpackage

// File: rtl/audio_bclk_gen.sv
// Free-running frame counter {slot, bit, phase} and the serial clocks/strobes
// derived from it.
module audio_bclk_gen
    import audio_if_pkg::*;
#(
    parameter int  NUM_CH        = DEF_NUM_CH,
    parameter int  SLOT_W        = DEF_SLOT_W,
    parameter int  BCLK_DIV_LOG2 = DEF_BCLK_DIV_LOG2,
    localparam int CH_W          = idx_w(NUM_CH),
    localparam int BIT_W         = idx_w(SLOT_W)
)(
    input  logic             clk,
    input  logic             rst,
    output logic             bclk,
    output logic             lrclk,
    output logic             new_frame,
    output logic             tx_en,
    output logic             rx_en,
    output logic [CH_W-1:0]  slot,
    output logic [BIT_W-1:0] bit_idx,
    output logic [CH_W-1:0]  nxt_slot,
    output logic [BIT_W-1:0] nxt_bit
);

    localparam int PH_W  = BCLK_DIV_LOG2;
    localparam int IDX_W = CH_W + BIT_W;
    localparam int CNT_W = IDX_W + PH_W;
    localparam logic [PH_W-1:0] RX_PHASE = PH_W'((1 << (PH_W - 1)) - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [PH_W-1:0]  phase;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign phase   = cnt_reg[PH_W-1:0];
    assign idx     = cnt_reg[CNT_W-1:PH_W];
    // Slot/bit of the bit period that starts after this cycle; only meaningful on tx_en.
    assign idx_inc = idx + IDX_W'(1);

    assign {slot, bit_idx}     = idx;
    assign {nxt_slot, nxt_bit} = idx_inc;

    assign bclk      = phase[PH_W-1];
    assign lrclk     = slot[CH_W-1];
    assign tx_en     = &phase;
    assign rx_en     = (phase == RX_PHASE);
    assign new_frame = &cnt_reg;

endmodule

// File: rtl/audio_tdm_codec_if.sv
// Parametrised I2S/TDM codec port: one-word play buffer feeding a per-frame
// shadow register, serial transmit/receive, and frame-wise record output.
module audio_tdm_codec_if
    import audio_if_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SLOT_W        = DEF_SLOT_W,
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int BCLK_DIV_LOG2 = DEF_BCLK_DIV_LOG2
)(
    input  logic                     audio_clk,
    input  logic                     reset,
    input  logic                     mode_i2s,
    input  logic [NUM_CH*DATA_W-1:0] play_data,
    input  logic                     play_valid,
    output logic                     play_ready,
    output logic [NUM_CH*DATA_W-1:0] rec_data,
    output logic                     rec_valid,
    output logic                     underrun,
    input  logic                     clr_underrun,
    output logic                     MCLK,
    output logic                     BCLK,
    output logic                     LRCLK,
    output logic                     NewFrame,
    input  logic                     ADC_SDATA,
    output logic                     DAC_SDATA
);

    localparam int CH_W   = idx_w(NUM_CH);
    localparam int BIT_W  = idx_w(SLOT_W);
    localparam int POS_W  = idx_w(DATA_W);
    localparam int WORD_W = NUM_CH * DATA_W;

    logic             tx_en;
    logic             rx_en;
    logic             frame_end;
    logic [CH_W-1:0]  slot;
    logic [CH_W-1:0]  nxt_slot;
    logic [BIT_W-1:0] bit_idx;
    logic [BIT_W-1:0] nxt_bit;

    audio_bclk_gen #(
        .NUM_CH        (NUM_CH),
        .SLOT_W        (SLOT_W),
        .BCLK_DIV_LOG2 (BCLK_DIV_LOG2)
    ) u_bclk_gen (
        .clk       (audio_clk),
        .rst       (reset),
        .bclk      (BCLK),
        .lrclk     (LRCLK),
        .new_frame (frame_end),
        .tx_en     (tx_en),
        .rx_en     (rx_en),
        .slot      (slot),
        .bit_idx   (bit_idx),
        .nxt_slot  (nxt_slot),
        .nxt_bit   (nxt_bit)
    );

    assign NewFrame = frame_end;
    assign MCLK     = ~audio_clk;

    logic [WORD_W-1:0] buf_reg;
    logic [WORD_W-1:0] buf_next;
    logic [WORD_W-1:0] shadow_reg;
    logic [WORD_W-1:0] shadow_next;
    logic [WORD_W-1:0] rec_asm;
    logic [WORD_W-1:0] rec_data_reg;
    logic              buf_full_reg;
    logic              buf_full_next;
    logic              mode_reg;
    logic              mode_next;
    logic              underrun_reg;
    logic              underrun_next;
    logic              dac_reg;
    logic              dac_next;
    logic              rec_valid_reg;
    logic              accept;
    logic [DATA_W-1:0] shadow_ch [NUM_CH];
    int                tx_d;
    int                rx_d;
    logic              rx_hit;
    logic [POS_W-1:0]  rx_pos;

    assign play_ready = ~buf_full_reg;
    assign accept     = play_valid & ~buf_full_reg;

    // At the boundary the shadow takes the buffered word, else a word offered
    // in that very cycle, else silence with a sticky underrun (set beats clear).
    always_comb begin
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        shadow_next   = shadow_reg;
        mode_next     = mode_reg;
        underrun_next = underrun_reg;
        if (clr_underrun) begin
            underrun_next = 1'b0;
        end
        if (frame_end) begin
            mode_next = mode_i2s;
            if (buf_full_reg) begin
                shadow_next   = buf_reg;
                buf_full_next = 1'b0;
            end else if (play_valid) begin
                shadow_next = play_data;
            end else begin
                shadow_next   = '0;
                underrun_next = 1'b1;
            end
        end else if (accept) begin
            buf_next      = play_data;
            buf_full_next = 1'b1;
        end
    end

    // Transmit uses the post-boundary shadow/mode so slot 0 bit 0 is correct.
    always_comb begin
        tx_d     = int'(nxt_bit) - int'(mode_next);
        dac_next = dac_reg;
        if (tx_en) begin
            dac_next = 1'b0;
            if (tx_d >= 0 && tx_d < DATA_W) begin
                dac_next = shadow_ch[nxt_slot][POS_W'(DATA_W - 1 - tx_d)];
            end
        end
    end

    always_comb begin
        rx_d   = int'(bit_idx) - int'(mode_reg);
        rx_hit = rx_en && (rx_d >= 0) && (rx_d < DATA_W);
        rx_pos = POS_W'(DATA_W - 1 - rx_d);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] asm_reg;

            assign shadow_ch[gi] = shadow_next[gi*DATA_W +: DATA_W];

            always_ff @(posedge audio_clk or posedge reset) begin
                if (reset) begin
                    asm_reg <= '0;
                end else if (rx_hit && slot == CH_W'(gi)) begin
                    asm_reg[rx_pos] <= ADC_SDATA;
                end
            end

            assign rec_asm[gi*DATA_W +: DATA_W] = asm_reg;
        end
    endgenerate

    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            buf_reg       <= '0;
            buf_full_reg  <= 1'b0;
            shadow_reg    <= '0;
            mode_reg      <= MODE_LJ;
            underrun_reg  <= 1'b0;
            dac_reg       <= 1'b0;
            rec_data_reg  <= '0;
            rec_valid_reg <= 1'b0;
        end else begin
            buf_reg       <= buf_next;
            buf_full_reg  <= buf_full_next;
            shadow_reg    <= shadow_next;
            mode_reg      <= mode_next;
            underrun_reg  <= underrun_next;
            dac_reg       <= dac_next;
            rec_valid_reg <= frame_end;
            if (frame_end) begin
                rec_data_reg <= rec_asm;
            end
        end
    end

    assign rec_data  = rec_data_reg;
    assign rec_valid = rec_valid_reg;
    assign underrun  = underrun_reg;
    assign DAC_SDATA = dac_reg;

endmodule

// File: tb/tb_audio_tdm_codec_if.sv
// Directed bench for audio_tdm_codec_if: default 2ch instance in loopback plus
// an 8ch/16-slot/12-bit instance for the multichannel case.
module tb_audio_tdm_codec_if;

    localparam int W  = 48;
    localparam int W8 = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          mode_i2s;
    logic [W-1:0]  play_data;
    logic          play_valid;
    logic          play_ready;
    logic [W-1:0]  rec_data;
    logic          rec_valid;
    logic          underrun;
    logic          clr_underrun;
    logic          mclk;
    logic          bclk;
    logic          lrclk;
    logic          new_frame;
    logic          dac;

    logic          mode8;
    logic [W8-1:0] p8_data;
    logic          p8_valid;
    logic          p8_ready;
    logic [W8-1:0] r8_data;
    logic          r8_valid;
    logic          ur8;
    logic          clr8;
    logic          mclk8;
    logic          bclk8;
    logic          lrclk8;
    logic          nf8;
    logic          dac8;

    int checks   = 0;
    int failures = 0;

    audio_tdm_codec_if u_dut (
        .audio_clk    (clk),
        .reset        (rst),
        .mode_i2s     (mode_i2s),
        .play_data    (play_data),
        .play_valid   (play_valid),
        .play_ready   (play_ready),
        .rec_data     (rec_data),
        .rec_valid    (rec_valid),
        .underrun     (underrun),
        .clr_underrun (clr_underrun),
        .MCLK         (mclk),
        .BCLK         (bclk),
        .LRCLK        (lrclk),
        .NewFrame     (new_frame),
        .ADC_SDATA    (dac),
        .DAC_SDATA    (dac)
    );

    audio_tdm_codec_if #(
        .DATA_W        (12),
        .SLOT_W        (16),
        .NUM_CH        (8),
        .BCLK_DIV_LOG2 (2)
    ) u_dut8 (
        .audio_clk    (clk),
        .reset        (rst),
        .mode_i2s     (mode8),
        .play_data    (p8_data),
        .play_valid   (p8_valid),
        .play_ready   (p8_ready),
        .rec_data     (r8_data),
        .rec_valid    (r8_valid),
        .underrun     (ur8),
        .clr_underrun (clr8),
        .MCLK         (mclk8),
        .BCLK         (bclk8),
        .LRCLK        (lrclk8),
        .NewFrame     (nf8),
        .ADC_SDATA    (dac8),
        .DAC_SDATA    (dac8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Advance to the next NewFrame cycle of the selected instance.
    task automatic wait_nf(input bit sel, output int ncyc, output int nrv);
        ncyc = 0;
        nrv  = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            ncyc++;
            if ((sel ? r8_valid : rec_valid) === 1'b1) nrv++;
            if ((sel ? nf8 : new_frame) === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_newframe actual=timeout required=pulse within 1100 cycles");
    endtask

    task automatic test_reset;
        int n;
        int nrv;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bclk, lrclk, new_frame, dac, rec_valid, underrun, play_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=0000001",
                     {bclk, lrclk, new_frame, dac, rec_valid, underrun, play_ready});
        end
        checks++;
        if (rec_data !== 48'h0) begin
            failures++;
            $display("FAIL reset_rec_data actual=%h required=0", rec_data);
        end
        checks++;
        if (mclk !== 1'b0) begin
            failures++;
            $display("FAIL mclk_inverted actual=%b required=0 while clk high", mclk);
        end
        rst = 1'b0;
        wait_nf(0, n, nrv);
        tick();
        repeat (99) tick();
        play_valid = 1'b1;
        play_data  = 48'h0F0F0F_F0F0F0;
        tick();
        play_valid = 1'b0;
        checks++;
        if ({underrun, play_ready} !== 2'b10) begin
            failures++;
            $display("FAIL pre_reset_state actual=%b required=10", {underrun, play_ready});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bclk, lrclk, new_frame, dac, rec_valid, underrun, play_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL midframe_reset_outputs actual=%b required=0000001",
                     {bclk, lrclk, new_frame, dac, rec_valid, underrun, play_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 1;
        while (new_frame !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 256) begin
            failures++;
            $display("FAIL first_newframe_cycle actual=%0d required=256", n);
        end
        wait_nf(0, n, nrv);
        checks++;
        if (n !== 256 || nrv !== 1) begin
            failures++;
            $display("FAIL frame_period actual=%0d/%0d required=256/1", n, nrv);
        end
    endtask

    task automatic test_lj_loopback;
        int n;
        int nrv;
        logic [W-1:0] word;
        word     = {24'h123456, 24'hABCDEF};
        mode_i2s = 1'b0;
        tick();
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL clr_underrun actual=%b required=0", underrun);
        end
        wait_nf(0, n, nrv);
        for (int f = 0; f < 5; f++) begin
            play_valid = 1'b1;
            play_data  = word;
            tick();
            play_valid = 1'b0;
            checks++;
            if (rec_valid !== 1'b1) begin
                failures++;
                $display("FAIL lj_rec_valid frame=%0d actual=%b required=1", f, rec_valid);
            end
            if (f >= 1) begin
                $display("lj frame %0d rec_data=%h", f, rec_data);
                checks++;
                if (rec_data !== word) begin
                    failures++;
                    $display("FAIL lj_rec_data frame=%0d actual=%h required=%h", f, rec_data, word);
                end
            end
            wait_nf(0, n, nrv);
            checks++;
            if (n !== 255 || nrv !== 0) begin
                failures++;
                $display("FAIL lj_rec_valid_rate frame=%0d actual=%0d/%0d required=255/0", f, n, nrv);
            end
        end
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL lj_no_underrun actual=%b required=0", underrun);
        end
    endtask

    task automatic test_i2s;
        int n;
        int nrv;
        logic exp_bit;
        mode_i2s   = 1'b1;
        play_valid = 1'b1;
        play_data  = {24'h000000, 24'h800001};
        tick();
        play_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (lrclk !== 1'b0) begin
            failures++;
            $display("FAIL i2s_lrclk_slot0 actual=%b required=0", lrclk);
        end
        for (int b = 0; b < 32; b++) begin
            exp_bit = (b == 1 || b == 24);
            checks++;
            if (dac !== exp_bit) begin
                failures++;
                $display("FAIL i2s_dac_bit bclk=%0d actual=%b required=%b", b + 1, dac, exp_bit);
            end
            if (b == 0) mode_i2s = 1'b0;
            repeat (4) tick();
        end
        $display("i2s slot0 word 800001 serialised");
        checks++;
        if (lrclk !== 1'b1) begin
            failures++;
            $display("FAIL i2s_lrclk_slot1 actual=%b required=1", lrclk);
        end
        wait_nf(0, n, nrv);
    endtask

    task automatic test_underrun;
        int ones;
        int lows;
        play_valid = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_pre actual=%b required=0", underrun);
        end
        tick();
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set actual=%b required=1", underrun);
        end
        ones = 0;
        lows = 0;
        for (int i = 0; i < 255; i++) begin
            if (dac !== 1'b0) ones++;
            if (underrun !== 1'b1) lows++;
            tick();
        end
        checks++;
        if (new_frame !== 1'b1) begin
            failures++;
            $display("FAIL underrun_frame_align actual=%b required=1", new_frame);
        end
        clr_underrun = 1'b1;
        tick();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set_wins actual=%b required=1", underrun);
        end
        for (int i = 0; i < 255; i++) begin
            if (dac !== 1'b0) ones++;
            if (i < 100 && underrun !== 1'b1) lows++;
            if (i == 100) begin
                clr_underrun = 1'b1;
                tick();
                clr_underrun = 1'b0;
                checks++;
                if (underrun !== 1'b0) begin
                    failures++;
                    $display("FAIL underrun_clear actual=%b required=0", underrun);
                end
            end else begin
                tick();
            end
        end
        checks++;
        if (ones !== 0 || lows !== 0) begin
            failures++;
            $display("FAIL underrun_silence actual=%0d/%0d required=0/0 (dac ones / early clears)", ones, lows);
        end
        play_valid = 1'b1;
        play_data  = 48'h000001_000001;
        tick();
        play_valid = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL valid_at_boundary actual=%b required=0", underrun);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int nrv;
        int idx;
        int nb;
        bit exp_full;
        bit hs;
        bit nf;
        logic [W-1:0] w [3];
        w[0] = {24'hA5A5A5, 24'h5A5A5A};
        w[1] = {24'h000FFF, 24'hFFF000};
        w[2] = {24'h765432, 24'h89ABCD};
        wait_nf(0, n, nrv);
        idx        = 0;
        nb         = 0;
        exp_full   = 1'b0;
        play_data  = w[0];
        play_valid = 1'b1;
        for (int c = 0; c < 1200 && nb < 4; c++) begin
            checks++;
            if (play_ready !== !exp_full) begin
                failures++;
                $display("FAIL b2b_ready cycle=%0d actual=%b required=%b", c, play_ready, !exp_full);
            end
            hs = play_valid && !exp_full;
            nf = (new_frame === 1'b1);
            tick();
            if (nf) exp_full = 1'b0;
            else if (hs) exp_full = 1'b1;
            if (hs) begin
                idx++;
                if (idx < 3) play_data = w[idx];
                else play_valid = 1'b0;
            end
            if (nf) begin
                nb++;
                checks++;
                if (rec_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_rec_valid boundary=%0d actual=%b required=1", nb, rec_valid);
                end
                if (nb >= 2) begin
                    $display("b2b boundary %0d rec_data=%h", nb, rec_data);
                    checks++;
                    if (rec_data !== w[nb-2]) begin
                        failures++;
                        $display("FAIL b2b_rec_data boundary=%0d actual=%h required=%h", nb, rec_data, w[nb-2]);
                    end
                end
            end
        end
        play_valid = 1'b0;
        checks++;
        if (idx !== 3 || nb !== 4) begin
            failures++;
            $display("FAIL b2b_words actual=%0d/%0d required=3/4", idx, nb);
        end
    endtask

    task automatic test_multich;
        int n;
        int nrv;
        logic [W8-1:0] words [10];
        for (int f = 0; f < 10; f++) begin
            words[f] = {$urandom(), $urandom(), $urandom()};
        end
        wait_nf(1, n, nrv);
        for (int f = 0; f < 11; f++) begin
            p8_valid = (f < 10);
            p8_data  = (f < 10) ? words[f] : '0;
            tick();
            p8_valid = 1'b0;
            checks++;
            if (r8_valid !== 1'b1) begin
                failures++;
                $display("FAIL mc_rec_valid frame=%0d actual=%b required=1", f, r8_valid);
            end
            if (f >= 1) begin
                $display("mc frame %0d rec_data=%h", f, r8_data);
                checks++;
                if (r8_data !== words[f-1]) begin
                    failures++;
                    $display("FAIL mc_rec_data frame=%0d actual=%h required=%h", f, r8_data, words[f-1]);
                end
            end
            if (f == 0) begin
                repeat (32) tick();
                for (int s = 0; s < 8; s++) begin
                    checks++;
                    if (lrclk8 !== (s >= 4)) begin
                        failures++;
                        $display("FAIL mc_lrclk slot=%0d actual=%b required=%b", s, lrclk8, (s >= 4));
                    end
                    if (s < 7) repeat (64) tick();
                end
            end
            wait_nf(1, n, nrv);
        end
    endtask

    initial begin
        rst          = 1'b1;
        mode_i2s     = 1'b0;
        play_data    = '0;
        play_valid   = 1'b0;
        clr_underrun = 1'b0;
        mode8        = 1'b0;
        p8_data      = '0;
        p8_valid     = 1'b0;
        clr8         = 1'b0;
        test_reset();
        test_lj_loopback();
        test_i2s();
        test_underrun();
        test_back_to_back();
        test_multich();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
